bin_frame_ctrl: RTL and testbench
=================================

BIN_FRAME_CTRL -- requirements
Module: bin_frame_ctrl

Interface
REQ-001 SHALL have parameter H_ACT, default 640, active pixels per line.
REQ-002 SHALL have parameter V_ACT, default 480, active lines per frame.
REQ-003 SHALL have parameter DEF_THRESH, default 50, threshold loaded at reset.
REQ-004 SHALL have port clk  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle pulse, begins one frame.
REQ-007 SHALL have port cfg_auto  in  1  1 = next threshold is the previous frame's mean gray.
REQ-008 SHALL have port cfg_thresh  in  8  manual threshold, used when cfg_auto=0.
REQ-009 SHALL have ports pix_valid in 1, pix_ready out 1, pix_rgb in 24 ({R,G,B}): the input pixel stream.
REQ-010 SHALL have ports bin_valid out 1, bin_ready in 1, bin_data out 1, bin_eol out 1, bin_eof out 1: the output bit stream.
REQ-011 SHALL have ports busy out 1, done out 1 (one-cycle pulse), thresh_cur out 8 (active threshold).

Function
REQ-012 SHALL implement FSM states IDLE, RUN, CALC, DONE.
REQ-013 IDLE: start=1 -> RUN; the threshold for the frame is latched as thresh_cur (if cfg_auto=0, thresh_cur := cfg_thresh; if cfg_auto=1, thresh_cur keeps the last computed mean); the column/row counters and gray sum are cleared.
REQ-014 Transfer rule: a pixel transfers when pix_valid and pix_ready are both 1; an output transfers when bin_valid and bin_ready are both 1.
REQ-015 pix_ready SHALL be 1 only in RUN, when all pixels are not yet accepted, and (!bin_valid || bin_ready).
REQ-016 Gray SHALL be (30*R + 59*G + 11*B + 50)/100, computed with at least 15-bit intermediate width, integer truncation, 8-bit result.
REQ-017 On an accepted pixel, in the next cycle: bin_valid=1; bin_data = (gray >= thresh_cur); bin_eol = (col==H_ACT-1); bin_eof = eol and (row==V_ACT-1). Latency is 1 cycle.
REQ-018 While bin_valid=1 and bin_ready=0, bin_data, bin_eol and bin_eof SHALL hold stable.
REQ-019 bin_valid SHALL clear after a transfer unless a new pixel is accepted in the same cycle.
REQ-020 col SHALL wrap from H_ACT-1 to 0 and increment row; no pixel is accepted after H_ACT*V_ACT pixels.
REQ-021 The gray sum SHALL be an unsigned accumulator of width clog2(H_ACT*V_ACT*255+1), added on each accepted pixel.
REQ-022 RUN SHALL exit after the eof output transfer: to CALC if cfg_auto=1 (sampled at that cycle), else to DONE.
REQ-023 CALC SHALL run a sequential restoring divider, 1 quotient bit per cycle: mean = sum / (H_ACT*V_ACT), truncated and saturated to 255; on completion thresh_cur := mean and the FSM goes to DONE.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 busy SHALL be 1 in RUN, CALC and DONE.
REQ-026 start outside IDLE SHALL be ignored; pix_valid outside RUN SHALL be ignored (no accept, no count).
REQ-027 An all-zero frame SHALL yield mean 0; a gray value equal to thresh_cur SHALL give bin_data=1.

Reset
REQ-028 rst_n=0 at any time, including mid-frame or mid-divide, SHALL immediately set: state=IDLE, pix_ready=0, bin_valid=0, bin_data=0, bin_eol=0, bin_eof=0, busy=0, done=0, thresh_cur=DEF_THRESH, counters=0, sum=0, divider cleared.
REQ-029 After release, the first frame SHALL require a fresh start pulse; partial-frame data is discarded.

Structure
REQ-030 The FSM state encoding, gray coefficients (30/59/11, rounding 50, divisor 100) and DEF_THRESH default SHALL live in shared package bin_pkg.
REQ-031 The gray computation SHALL be the combinational sub-module rgb2gray (in pix_rgb[23:0], out gray[7:0]); the divider SHALL be inline.

Verification (bench uses H_ACT=4, V_ACT=2)
REQ-032 cfg_auto=0, cfg_thresh=50; pixels 0x323232, 0x313131, 0xFFFFFF, 0x000000 x2 lines -> bin_data 1,0,1,0 per line; eol on the 4th and 8th outputs; eof on the 8th; done pulse 1 cycle later.
REQ-033 cfg_auto=1, 8 pixels of 0x646464 -> CALC, then thresh_cur=100 at done; the next frame with 0x636363 gives all bin_data=0.
REQ-034 Backpressure: bin_ready=0 for 5 cycles mid-frame -> pix_ready=0 and the output is held stable; no pixel is lost or duplicated; the output count is 8.
REQ-035 A start pulse during RUN -> no effect; a pix_valid pulse in IDLE -> no output and counters stay 0.
REQ-036 rst_n low after 3 pixels, and again during CALC -> all outputs at reset values and thresh_cur=50; the next start processes a full fresh 8-pixel frame.
REQ-037 cfg_auto=1 with an all-0x000000 frame -> thresh_cur=0; the next frame gives all bin_data=1.

Source files
------------

// File: rtl/bin_pkg.sv
// Shared definitions for the binarising frame controller: FSM encoding,
// gray-conversion coefficients and the reset threshold.
package bin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int GRAY_CR  = 30;
    localparam int GRAY_CG  = 59;
    localparam int GRAY_CB  = 11;
    localparam int GRAY_RND = 50;
    localparam int GRAY_DIV = 100;

    localparam int DEF_THRESH_INIT = 50;

endpackage

// File: rtl/rgb2gray.sv
// Combinational luma approximation: (30R + 59G + 11B + 50) / 100, 8-bit result.
module rgb2gray
    import bin_pkg::*;
(
    input  logic [23:0] pix_rgb,
    output logic [7:0]  gray
);

    logic [15:0] wsum;

    // 16-bit intermediate: worst case 100*255 + 50 = 25550
    always_comb begin
        wsum = 16'(GRAY_CR) * {8'd0, pix_rgb[23:16]}
             + 16'(GRAY_CG) * {8'd0, pix_rgb[15:8]}
             + 16'(GRAY_CB) * {8'd0, pix_rgb[7:0]}
             + 16'(GRAY_RND);
        gray = 8'(wsum / 16'(GRAY_DIV));
    end

endmodule

// File: rtl/bin_frame_ctrl.sv
// Frame binariser: thresholds an RGB pixel stream into a 1-bit stream and can
// derive the next frame's threshold from this frame's mean gray level.
module bin_frame_ctrl
    import bin_pkg::*;
#(
    parameter int H_ACT      = 640,
    parameter int V_ACT      = 480,
    parameter int DEF_THRESH = DEF_THRESH_INIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cfg_auto,
    input  logic [7:0]  cfg_thresh,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [23:0] pix_rgb,
    output logic        bin_valid,
    input  logic        bin_ready,
    output logic        bin_data,
    output logic        bin_eol,
    output logic        bin_eof,
    output logic        busy,
    output logic        done,
    output logic [7:0]  thresh_cur
);

    localparam int NPIX = H_ACT * V_ACT;
    localparam int SW   = $clog2(NPIX * 255 + 1);
    localparam int DW   = $clog2(NPIX + 1);
    localparam int CW   = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int RW   = (V_ACT > 1) ? $clog2(V_ACT) : 1;
    localparam int QCW  = $clog2(SW + 1);

    state_t          state_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    logic            all_acc_q;
    logic [SW-1:0]   sum_q;
    logic            bin_valid_q, bin_data_q, bin_eol_q, bin_eof_q;
    logic [7:0]      thresh_q;
    logic [DW-1:0]   rem_q;
    logic [SW-1:0]   quo_q;
    logic [QCW-1:0]  step_q;

    logic [7:0]      gray;
    logic            accept, out_xfer, last_col, last_row;
    logic [DW:0]     rem_sh;
    logic [DW-1:0]   rem_d;
    logic [SW-1:0]   quo_d;
    logic [7:0]      mean_d;

    rgb2gray u_gray (
        .pix_rgb (pix_rgb),
        .gray    (gray)
    );

    assign pix_ready  = (state_q == ST_RUN) && !all_acc_q && (!bin_valid_q || bin_ready);
    assign accept     = pix_valid && pix_ready;
    assign out_xfer   = bin_valid_q && bin_ready;
    assign last_col   = (col_q == CW'(H_ACT - 1));
    assign last_row   = (row_q == RW'(V_ACT - 1));

    assign bin_valid  = bin_valid_q;
    assign bin_data   = bin_data_q;
    assign bin_eol    = bin_eol_q;
    assign bin_eof    = bin_eof_q;
    assign thresh_cur = thresh_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

    // One restoring-division step: dividend bits shift out of quo_q's MSB
    // while quotient bits shift in at its LSB.
    always_comb begin
        rem_sh = {rem_q, quo_q[SW-1]};
        rem_d  = rem_sh[DW-1:0];
        quo_d  = {quo_q[SW-2:0], 1'b0};
        if (rem_sh >= (DW+1)'(NPIX)) begin
            rem_d    = DW'(rem_sh - (DW+1)'(NPIX));
            quo_d[0] = 1'b1;
        end
        mean_d = (quo_d > SW'(255)) ? 8'hFF : quo_d[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            all_acc_q   <= 1'b0;
            sum_q       <= '0;
            bin_valid_q <= 1'b0;
            bin_data_q  <= 1'b0;
            bin_eol_q   <= 1'b0;
            bin_eof_q   <= 1'b0;
            thresh_q    <= 8'(DEF_THRESH);
            rem_q       <= '0;
            quo_q       <= '0;
            step_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        col_q     <= '0;
                        row_q     <= '0;
                        all_acc_q <= 1'b0;
                        sum_q     <= '0;
                        if (!cfg_auto) thresh_q <= cfg_thresh;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        bin_valid_q <= 1'b1;
                        bin_data_q  <= (gray >= thresh_q);
                        bin_eol_q   <= last_col;
                        bin_eof_q   <= last_col && last_row;
                        sum_q       <= sum_q + SW'(gray);
                        if (last_col) begin
                            col_q <= '0;
                            row_q <= last_row ? '0 : row_q + RW'(1);
                            if (last_row) all_acc_q <= 1'b1;
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end else if (out_xfer) begin
                        bin_valid_q <= 1'b0;
                    end
                    if (out_xfer && bin_eof_q) begin
                        if (cfg_auto) begin
                            state_q <= ST_CALC;
                            quo_q   <= sum_q;
                            rem_q   <= '0;
                            step_q  <= '0;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_CALC: begin
                    rem_q  <= rem_d;
                    quo_q  <= quo_d;
                    step_q <= step_q + QCW'(1);
                    if (step_q == QCW'(SW - 1)) begin
                        thresh_q <= mean_d;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_frame_ctrl.sv
// Self-checking bench for bin_frame_ctrl with a 4x2 frame and an output scoreboard.
module tb_bin_frame_ctrl;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int NP = H * V;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cfg_auto = 1'b0;
    logic [7:0]  cfg_thresh = 8'd0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [23:0] pix_rgb = 24'h0;
    logic        bin_valid;
    logic        bin_ready = 1'b1;
    logic        bin_data, bin_eol, bin_eof;
    logic        busy, done;
    logic [7:0]  thresh_cur;

    always #5 clk = ~clk;

    bin_frame_ctrl #(.H_ACT(H), .V_ACT(V), .DEF_THRESH(50)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_auto   (cfg_auto),
        .cfg_thresh (cfg_thresh),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_rgb    (pix_rgb),
        .bin_valid  (bin_valid),
        .bin_ready  (bin_ready),
        .bin_data   (bin_data),
        .bin_eol    (bin_eol),
        .bin_eof    (bin_eof),
        .busy       (busy),
        .done       (done),
        .thresh_cur (thresh_cur)
    );

    int errors = 0;
    int checks = 0;
    int model_thresh = 50;
    logic [2:0] exp_q[$];

    function automatic int gray_of(input logic [23:0] p);
        return (30 * int'(p[23:16]) + 59 * int'(p[15:8]) + 11 * int'(p[7:0]) + 50) / 100;
    endfunction

    task automatic start_frame(input logic auto_i, input logic [7:0] thr);
        @(negedge clk);
        cfg_auto   = auto_i;
        cfg_thresh = thr;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (!auto_i) model_thresh = int'(thr);
        #1;
        checks++;
        if (busy !== 1'b1 || thresh_cur !== 8'(model_thresh)) begin
            errors++;
            $display("FAIL start_frame: busy=%b thresh=%0d, required busy=1 thresh=%0d", busy, thresh_cur, model_thresh);
        end
    endtask

    // Drives one whole frame; scoreboard entries are pushed on each accepted pixel.
    task automatic drive_frame(input logic [23:0] px[NP], input int stall_at, input int stall_len,
                               input int start_at);
        int idx; int cyc; int nout; logic have_held;
        logic [2:0] held; logic [2:0] got; logic [2:0] exp;
        idx = 0; cyc = 0; nout = 0; have_held = 1'b0; held = '0;
        while (nout < NP && cyc < 300) begin
            pix_valid = (idx < NP);
            pix_rgb   = 24'h0;
            if (idx < NP) pix_rgb = px[idx];
            bin_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            start     = (cyc == start_at);
            #1;
            got = {bin_data, bin_eol, bin_eof};
            if (!bin_ready && bin_valid) begin
                checks++;
                if (pix_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready: pix_ready=%b required 0 (cycle %0d)", pix_ready, cyc);
                end
                if (have_held) begin
                    checks++;
                    if (got !== held) begin
                        errors++;
                        $display("FAIL stall_hold: {data,eol,eof}=%b required %b", got, held);
                    end
                end
                held = got;
                have_held = 1'b1;
            end else begin
                have_held = 1'b0;
            end
            if (bin_valid && bin_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: {data,eol,eof}=%b required none", got);
                end else begin
                    exp = exp_q.pop_front();
                    $display("out %0d: data=%b eol=%b eof=%b", nout, bin_data, bin_eol, bin_eof);
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL output %0d: {data,eol,eof}=%b required %b", nout, got, exp);
                    end
                end
                nout++;
            end
            if (pix_valid && pix_ready) begin
                exp_q.push_back({gray_of(px[idx]) >= model_thresh, (idx % H) == H - 1, idx == NP - 1});
                idx++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        pix_valid = 1'b0;
        bin_ready = 1'b1;
        start     = 1'b0;
        checks++;
        if (nout != NP || exp_q.size() != 0) begin
            errors++;
            $display("FAIL frame_count: outputs=%0d pending=%0d, required %0d and 0", nout, exp_q.size(), NP);
        end
        exp_q.delete();
    endtask

    task automatic wait_done(input int exp_wait);
        int n;
        n = 0;
        #1;
        while (done !== 1'b1 && n < 60) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (done !== 1'b1 || (exp_wait >= 0 && n != exp_wait)) begin
            errors++;
            $display("FAIL done_timing: done=%b after %0d cycles, required 1 after %0d", done, n, exp_wait);
        end
        checks++;
        if (thresh_cur !== 8'(model_thresh)) begin
            errors++;
            $display("FAIL thresh_at_done: thresh=%0d required %0d", thresh_cur, model_thresh);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({pix_ready, bin_valid, bin_data, bin_eol, bin_eof, busy, done, thresh_cur} !== {7'b0, 8'd50}) begin
            errors++;
            $display("FAIL reset_state: outs=%b thresh=%0d, required 0000000 and 50",
                     {pix_ready, bin_valid, bin_data, bin_eol, bin_eof, busy, done}, thresh_cur);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_manual();
        logic [23:0] p[NP];
        p = '{24'h323232, 24'h313131, 24'hFFFFFF, 24'h000000,
              24'h323232, 24'h313131, 24'hFFFFFF, 24'h000000};
        start_frame(1'b0, 8'd50);
        drive_frame(p, -1, 0, -1);
        wait_done(0);
    endtask

    task automatic test_auto(input logic [23:0] fill, input logic [23:0] next_fill, input logic [7:0] exp_mean);
        logic [23:0] p[NP];
        int sum;
        sum = 0;
        for (int i = 0; i < NP; i++) begin
            p[i] = fill;
            sum += gray_of(fill);
        end
        start_frame(1'b1, 8'd0);
        drive_frame(p, -1, 0, -1);
        model_thresh = (sum / NP > 255) ? 255 : sum / NP;
        wait_done(-1);
        checks++;
        if (thresh_cur !== exp_mean) begin
            errors++;
            $display("FAIL auto_mean: thresh=%0d required %0d", thresh_cur, exp_mean);
        end
        for (int i = 0; i < NP; i++) p[i] = next_fill;
        start_frame(1'b0, exp_mean);
        drive_frame(p, -1, 0, -1);
        wait_done(0);
    endtask

    task automatic test_backpressure();
        logic [23:0] p[NP];
        for (int i = 0; i < NP; i++) p[i] = 24'(i * 24'h202020 + 24'h102030);
        start_frame(1'b0, 8'd90);
        drive_frame(p, 3, 5, -1);
        wait_done(0);
    endtask

    task automatic test_ignore();
        logic [23:0] p[NP];
        @(negedge clk);
        pix_valid = 1'b1;
        pix_rgb   = 24'hFFFFFF;
        #1;
        checks++;
        if (pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: pix_ready=%b required 0", pix_ready);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        #1;
        checks++;
        if (bin_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_pixel: bin_valid=%b busy=%b required 0 0", bin_valid, busy);
        end
        for (int i = 0; i < NP; i++) p[i] = (i % 2 == 0) ? 24'h808080 : 24'h202020;
        start_frame(1'b0, 8'd100);
        drive_frame(p, -1, 0, 3);
        wait_done(0);
    endtask

    task automatic test_reset_mid();
        logic [23:0] p[NP];
        for (int i = 0; i < NP; i++) p[i] = 24'h646464;
        start_frame(1'b0, 8'd10);
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1'b1;
            pix_rgb   = 24'hFFFFFF;
            @(posedge clk);
            @(negedge clk);
        end
        pix_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_thresh = 50;
        checks++;
        if ({pix_ready, bin_valid, bin_data, bin_eol, bin_eof, busy, done, thresh_cur} !== {7'b0, 8'd50}) begin
            errors++;
            $display("FAIL reset_midframe: outs=%b thresh=%0d, required 0000000 and 50",
                     {pix_ready, bin_valid, bin_data, bin_eol, bin_eof, busy, done}, thresh_cur);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pix_valid = 1'b1;
        #1;
        checks++;
        if (pix_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL no_auto_restart: pix_ready=%b busy=%b required 0 0", pix_ready, busy);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        start_frame(1'b1, 8'd0);
        drive_frame(p, -1, 0, -1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL calc_state: busy=%b done=%b required 1 0", busy, done);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bin_valid, busy, done, thresh_cur} !== {3'b0, 8'd50}) begin
            errors++;
            $display("FAIL reset_calc: valid/busy/done=%b thresh=%0d, required 000 and 50",
                     {bin_valid, busy, done}, thresh_cur);
        end
        @(negedge clk);
        rst_n = 1'b1;
        p = '{24'h323232, 24'h313131, 24'hFFFFFF, 24'h000000,
              24'h000000, 24'hFFFFFF, 24'h313131, 24'h323232};
        start_frame(1'b0, 8'd50);
        drive_frame(p, -1, 0, -1);
        wait_done(0);
    endtask

    initial begin
        test_reset();
        test_manual();
        test_auto(24'h646464, 24'h636363, 8'd100);
        test_backpressure();
        test_ignore();
        test_reset_mid();
        test_auto(24'h000000, 24'h000000, 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
